fsm22_decoder: RTL and testbench

FSM22_DECODER -- requirements
Module: fsm22_decoder

---
 rtl/fsm22_decoder.sv | 106 ++++++++++
 tb/tb_fsm22_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fsm22_decoder.sv
// Inverts the fsm22 encoder: tracks the encoder state from the recovered bits
// and regroups the recovered stream into bytes.
module fsm22_decoder #(
   parameter int LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       Ein,
   input  logic       Ein_valid,
   input  logic       Resync,
   output logic       Dout,
   output logic       Dout_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S0 = 4'b0001,
      S1 = 4'b0010,
      S2 = 4'b0100,
      S3 = 4'b1000
   } state_t;

   state_t     state_reg, state_next;
   logic [2:0] count_reg, count_next;
   logic [7:0] shift_reg, shift_next;
   logic       dout_reg, dout_next;
   logic       dout_valid_reg, dout_valid_next;
   logic [7:0] byte_reg, byte_next;
   logic       byte_valid_reg, byte_valid_next;

   // Working copies after Resync and illegal-state cleanup are applied.
   state_t     cur_state;
   logic [2:0] cur_count;
   logic [7:0] cur_shift;
   logic       d;

   always_comb begin
      cur_state = S0;
      case (state_reg)
         S0, S1, S2, S3: cur_state = state_reg;
         default:        cur_state = S0;
      endcase
      if (Resync) begin
         cur_state = S0;
      end
      cur_count = Resync ? 3'd0 : count_reg;
      cur_shift = Resync ? 8'h00 : shift_reg;
      d         = Ein ^ (cur_state == S1);

      state_next      = cur_state;
      count_next      = cur_count;
      shift_next      = cur_shift;
      dout_next       = dout_reg;
      dout_valid_next = 1'b0;
      byte_next       = byte_reg;
      byte_valid_next = 1'b0;

      if (Ein_valid) begin
         case (cur_state)
            S0:      state_next = d ? S1 : S0;
            S1:      state_next = d ? S3 : S2;
            S2:      state_next = d ? S3 : S0;
            S3:      state_next = d ? S0 : S3;
            default: state_next = S0;
         endcase
         count_next      = cur_count + 3'd1;
         shift_next      = (LSB_FIRST != 0) ? {d, cur_shift[7:1]} : {cur_shift[6:0], d};
         dout_next       = d;
         dout_valid_next = 1'b1;
         // The eighth bit completes the byte on the same edge it is decoded.
         if (cur_count == 3'd7) begin
            byte_next       = shift_next;
            byte_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg      <= S0;
         count_reg      <= 3'd0;
         shift_reg      <= 8'h00;
         dout_reg       <= 1'b0;
         dout_valid_reg <= 1'b0;
         byte_reg       <= 8'h00;
         byte_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         shift_reg      <= shift_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         byte_reg       <= byte_next;
         byte_valid_reg <= byte_valid_next;
      end
   end

   assign Dout       = dout_reg;
   assign Dout_valid = dout_valid_reg;
   assign byte_out   = byte_reg;
   assign byte_valid = byte_valid_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_fsm22_decoder.sv
// Drives two decoders (LSB-first and MSB-first) with directed and random
// streams and compares them against a table-driven encoder/decoder model.
module tb_fsm22_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       Reset_n, Ein, Ein_valid, Resync;
   logic       dout1, dv1, bv1, dout0, dv0, bv0;
   logic [7:0] byte1, byte0;
   logic [3:0] st1, st0;

   fsm22_decoder #(.LSB_FIRST(1)) dut_lsb (
      .clk(clk), .Reset_n(Reset_n), .Ein(Ein), .Ein_valid(Ein_valid), .Resync(Resync),
      .Dout(dout1), .Dout_valid(dv1), .byte_out(byte1), .byte_valid(bv1), .state(st1)
   );

   fsm22_decoder #(.LSB_FIRST(0)) dut_msb (
      .clk(clk), .Reset_n(Reset_n), .Ein(Ein), .Ein_valid(Ein_valid), .Resync(Resync),
      .Dout(dout0), .Dout_valid(dv0), .byte_out(byte0), .byte_valid(bv0), .state(st0)
   );

   int checks = 0;
   int errors = 0;

   // Encoder transition table indexed [state][original bit], states numbered 0..3.
   int ntab [4][2] = '{'{0, 1}, '{2, 3}, '{0, 3}, '{3, 0}};

   int         ms, mcnt;
   logic       mbits [8];
   logic       exp_dout, exp_dv, exp_bv;
   logic [7:0] exp_lsb, exp_msb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0; mcnt = 0;
      exp_dout = 1'b0; exp_dv = 1'b0; exp_bv = 1'b0;
      exp_lsb = 8'h00; exp_msb = 8'h00;
   endtask

   task automatic model_step(input logic ein, input logic v, input logic rs);
      logic d;
      exp_dv = 1'b0;
      exp_bv = 1'b0;
      if (rs) begin
         ms = 0; mcnt = 0;
      end
      if (v) begin
         d = ein ^ (ms == 1);
         exp_dout = d;
         exp_dv = 1'b1;
         mbits[mcnt] = d;
         ms = ntab[ms][d];
         if (mcnt == 7) begin
            for (int i = 0; i < 8; i++) begin
               exp_lsb[i]     = mbits[i];
               exp_msb[7 - i] = mbits[i];
            end
            exp_bv = 1'b1;
         end
         mcnt = (mcnt + 1) % 8;
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] exp_st;
      exp_st = 4'b0001 << ms;
      chk({tag, ".dout"},   dout1, exp_dout);
      chk({tag, ".dv"},     dv1,   exp_dv);
      chk({tag, ".state"},  st1,   exp_st);
      chk({tag, ".byte"},   byte1, exp_lsb);
      chk({tag, ".bv"},     bv1,   exp_bv);
      chk({tag, ".dout_m"}, dout0, exp_dout);
      chk({tag, ".dv_m"},   dv0,   exp_dv);
      chk({tag, ".state_m"},st0,   exp_st);
      chk({tag, ".byte_m"}, byte0, exp_msb);
      chk({tag, ".bv_m"},   bv0,   exp_bv);
   endtask

   task automatic step(input string tag, input logic ein, input logic v, input logic rs);
      Ein = ein; Ein_valid = v; Resync = rs;
      @(posedge clk);
      #1;
      model_step(ein, v, rs);
      $display("%s t=%0t ein=%b v=%b rs=%b dout=%b dv=%b st=%b byte=%h/%h bv=%b",
               tag, $time, ein, v, rs, dout1, dv1, st1, byte1, byte0, bv1);
      check_all(tag);
   endtask

   logic [7:0] stream_a5 = 8'b1010_0111; // Ein bits 1,1,1,0,0,1,0,1 read from bit 0 upward
   logic [3:0] req23_st [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0001};
   logic       req23_do [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
   logic [3:0] req23_ein = 4'b0101;     // 1,0,1,0 read from bit 0 upward

   initial begin
      int es;
      logic din, ein;
      Reset_n = 1'b0; Ein = 1'b0; Ein_valid = 1'b0; Resync = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      Reset_n = 1'b1;

      // Short stream from S0
      for (int i = 0; i < 4; i++) begin
         step("req23", req23_ein[i], 1'b1, 1'b0);
         chk("req23.dout_const", dout1, req23_do[i]);
         chk("req23.state_const", st1, req23_st[i]);
      end

      // Full byte, continuous then with 3-cycle gaps
      step("resync", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step("req24", stream_a5[i], 1'b1, 1'b0);
      chk("req24.byte_lsb", byte1, 8'hA5);
      chk("req24.byte_msb", byte0, 8'hA5);
      chk("req24.state_final", st1, 4'b0010);
      step("resync", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step("req25", stream_a5[i], 1'b1, 1'b0);
         for (int g = 0; g < 3; g++) step("req25gap", $urandom_range(0, 1), 1'b0, 1'b0);
      end
      chk("req25.byte_lsb", byte1, 8'hA5);

      // Resync colliding with a valid bit after four bits
      for (int i = 0; i < 4; i++) step("req26pre", $urandom_range(0, 1), 1'b1, 1'b0);
      step("req26", 1'b1, 1'b1, 1'b1);
      chk("req26.dout", dout1, 1'b1);
      chk("req26.state", st1, 4'b0010);
      chk("req26.bv", bv1, 1'b0);
      for (int i = 0; i < 7; i++) step("req26post", $urandom_range(0, 1), 1'b1, 1'b0);
      chk("req26.bv_after7", bv1, 1'b1);

      // Asynchronous reset mid-byte
      for (int i = 0; i < 3; i++) step("req27pre", $urandom_range(0, 1), 1'b1, 1'b0);
      Ein_valid = 1'b0;
      #3;
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("req27rst");
      @(negedge clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 8; i++) step("req27post", $urandom_range(0, 1), 1'b1, 1'b0);
      chk("req27.bv", bv1, 1'b1);

      // Encoder loopback
      step("resync", 1'b0, 1'b0, 1'b1);
      es = 0;
      for (int i = 0; i < 64; i++) begin
         din = 1'($urandom_range(0, 1));
         ein = din ^ (es == 1);
         es  = ntab[es][din];
         step("loop", ein, 1'b1, 1'b0);
         chk("loop.recovered", dout1, din);
      end

      // Random traffic with gaps and occasional resync
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
